redirect_ctrl: RTL and testbench

Control-flow redirect sequencer for the single-issue RISC-V core. It accepts PC-update requests from the jump unit (JAL/JALR) and the branch unit, and picks one per event. It registers the target, holds a valid/ready handshake with fetch until the new PC is accepted, then squashes the younger in-flight instructions for a fixed number of cycles. It sits between the execute-stage control-flow units and the fetch stage, and owns the pipeline flush/stall lines.

---
 rtl/redirect_pkg.sv | 32 +++
 rtl/redirect_arb.sv | 29 ++
 rtl/redirect_ctrl.sv | 148 ++++++++++++++
 tb/tb_redirect_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/redirect_pkg.sv
// Shared types and constants for the control-flow redirect sequencer.
// Optional feature macro: MISALIGN_CHECK_EN (target alignment trap).
package redirect_pkg;

    // Sequencer states: waiting, holding the fetch handshake, squashing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } redirect_state_e;

    // Which execute-stage unit won arbitration.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        JMP  = 2'd1,
        BR   = 2'd2
    } redirect_src_e;

    // Width of the post-handshake flush counter.
    localparam int CNT_W = 4;

    // Bit 0 of every target is cleared before it reaches fetch.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFE;

    // Bit 1 set means the target is not on a 4-byte boundary.
    localparam logic [31:0] PC_MISALIGN_BIT = 32'h0000_0002;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return |(pc & PC_MISALIGN_BIT);
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Priority select between the jump and branch redirect requests.
// The jump unit always wins; a simultaneous branch request is dropped.
module redirect_arb
    import redirect_pkg::*;
(
    input  logic          jmp_req,
    input  logic [31:0]   jmp_target,
    input  logic          br_req,
    input  logic [31:0]   br_target,
    output logic          sel_req,
    output logic [31:0]   sel_target,
    output redirect_src_e sel_src
);

    // Pick the winning request and clear bit 0 of its target.
    always_comb begin
        sel_req    = jmp_req | br_req;
        sel_target = '0;
        sel_src    = NONE;
        if (jmp_req) begin
            sel_target = jmp_target & PC_ALIGN_MASK;
            sel_src    = JMP;
        end else if (br_req) begin
            sel_target = br_target & PC_ALIGN_MASK;
            sel_src    = BR;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Control-flow redirect sequencer: latches one redirect per event, holds a
// valid/ready handshake with fetch, then squashes younger instructions for
// FLUSH_CYCLES cycles (legal range 1..15).
// Optional feature macro: MISALIGN_CHECK_EN adds the misalign_err port and
// rejects targets whose bit 1 is set.
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        stall
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    logic            sel_req;
    logic [31:0]     sel_target;
    redirect_src_e   sel_src;
    logic            take;

    redirect_state_e state_reg;
    redirect_state_e state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic            valid_next;
    logic            flush_next;
    logic            stall_next;
    logic [31:0]     pc_next;
`ifdef MISALIGN_CHECK_EN
    logic            mis_next;
`endif

    redirect_arb u_arb (
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .br_req     (br_req),
        .br_target  (br_target),
        .sel_req    (sel_req),
        .sel_target (sel_target),
        .sel_src    (sel_src)
    );

    assign take = sel_req && (sel_src != NONE);

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        valid_next = 1'b0;
        flush_next = 1'b0;
        stall_next = 1'b0;
        pc_next    = redirect_pc;
`ifdef MISALIGN_CHECK_EN
        mis_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (take) begin
`ifdef MISALIGN_CHECK_EN
                    if (is_misaligned(sel_target)) begin
                        // Trap unit handles it; no redirect is issued.
                        mis_next = 1'b1;
                    end else begin
                        state_next = REQ;
                        pc_next    = sel_target;
                        valid_next = 1'b1;
                        flush_next = 1'b1;
                        stall_next = 1'b1;
                    end
`else
                    state_next = REQ;
                    pc_next    = sel_target;
                    valid_next = 1'b1;
                    flush_next = 1'b1;
                    stall_next = 1'b1;
`endif
                end
            end
            REQ: begin
                // Requests seen here belong to squashed instructions.
                flush_next = 1'b1;
                if (fetch_ready) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_W'(FLUSH_CYCLES);
                end else begin
                    valid_next = 1'b1;
                    stall_next = 1'b1;
                end
            end
            FLUSH: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = IDLE;
                end else begin
                    flush_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops any redirect.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            stall          <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            redirect_valid <= valid_next;
            redirect_pc    <= pc_next;
            flush          <= flush_next;
            stall          <= stall_next;
        end
    end

`ifdef MISALIGN_CHECK_EN
    // One-cycle misalignment pulse toward the trap unit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= mis_next;
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: the driver pushes the expected redirect
// episode for each accepted request, the monitor pops and checks it when the
// DUT raises redirect_valid (or misalign_err when MISALIGN_CHECK_EN is set).
module tb_redirect_ctrl;

    localparam int FC = 2;

    logic        i_clk;
    logic        i_rst;
    logic        jmp_req;
    logic [31:0] jmp_target;
    logic        br_req;
    logic [31:0] br_target;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        stall;
`ifdef MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .jmp_req        (jmp_req),
        .jmp_target     (jmp_target),
        .br_req         (br_req),
        .br_target      (br_target),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall          (stall)
`ifdef MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          mis;
        logic [31:0] pc;
        int          wait_cycles;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Monitor episode bookkeeping
    bit          in_ep = 1'b0;
    logic [31:0] ep_pc;
    int          ep_w;
    int          vcnt;
    int          fcnt;
    bit          prev_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_reqs();
        jmp_req = 1'b0;
        br_req  = 1'b0;
    endtask

    // One redirect transaction: request now, fetch stalls for w cycles,
    // then FC flush cycles. noise injects requests that must be ignored.
    task automatic txn(input bit use_j, input bit use_b, input logic [31:0] jt,
                       input logic [31:0] bt, input int w, input bit noise);
        logic [31:0] sel;
        exp_t e;
        jmp_req     = use_j;
        br_req      = use_b;
        jmp_target  = jt;
        br_target   = bt;
        fetch_ready = 1'($urandom);
        sel = use_j ? jt : bt;
        $display("[TB] txn j=%0b b=%0b jt=%h bt=%h wait=%0d", use_j, use_b, jt, bt, w);
`ifdef MISALIGN_CHECK_EN
        if (sel[1]) begin
            e.mis = 1'b1; e.pc = '0; e.wait_cycles = 0;
            exp_q.push_back(e);
            step();
            clear_reqs();
            step();
            return;
        end
`endif
        e.mis = 1'b0;
        e.pc  = {sel[31:1], 1'b0};
        e.wait_cycles = w;
        exp_q.push_back(e);
        step();
        for (int i = 0; i <= w; i++) begin
            fetch_ready = (i == w);
            jmp_req     = noise ? 1'($urandom) : 1'b0;
            br_req      = noise ? 1'($urandom) : 1'b0;
            jmp_target  = $urandom;
            br_target   = $urandom;
            step();
        end
        for (int i = 0; i < FC; i++) begin
            fetch_ready = 1'($urandom);
            jmp_req     = noise ? 1'($urandom) : 1'b0;
            br_req      = noise;
            br_target   = 32'h0000_0400;
            step();
        end
        clear_reqs();
    endtask

    // Monitor: checks each redirect episode against the popped expectation.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            in_ep    = 1'b0;
            prev_mis = 1'b0;
        end else begin
`ifdef MISALIGN_CHECK_EN
            if (misalign_err) begin
                exp_t m;
                check("misalign_single_cycle", {31'd0, prev_mis}, 32'd0);
                check("misalign_no_valid", {31'd0, redirect_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("misalign_unexpected", 32'd1, 32'd0);
                end else begin
                    m = exp_q.pop_front();
                    check("misalign_expected_kind", {31'd0, m.mis}, 32'd1);
                end
            end
            prev_mis = misalign_err;
`endif
            if (redirect_valid && !in_ep) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("redirect_kind", {31'd0, e.mis}, 32'd0);
                    check("redirect_pc", redirect_pc, e.pc);
                    ep_pc = e.pc;
                    ep_w  = e.wait_cycles;
                    vcnt  = 0;
                    fcnt  = 0;
                    in_ep = 1'b1;
                end
            end
            if (in_ep) begin
                if (redirect_valid) begin
                    vcnt++;
                    check("pc_stable", redirect_pc, ep_pc);
                end
                check("stall_tracks_valid", {31'd0, stall}, {31'd0, redirect_valid});
                if (flush) begin
                    fcnt++;
                end else begin
                    check("valid_cycles", vcnt, ep_w + 1);
                    check("flush_cycles", fcnt, ep_w + 1 + FC);
                    in_ep = 1'b0;
                end
            end else begin
                check("idle_flush", {31'd0, flush}, 32'd0);
                check("idle_stall", {31'd0, stall}, 32'd0);
            end
        end
    end

    initial begin
        i_rst       = 1'b0;
        jmp_req     = 1'b1;
        jmp_target  = 32'h0000_1235;
        br_req      = 1'b0;
        br_target   = '0;
        fetch_ready = 1'b1;

        // Reset held with a pending jump request: everything stays low.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("rst_valid", {31'd0, redirect_valid}, 32'd0);
            check("rst_pc", redirect_pc, 32'd0);
            check("rst_flush", {31'd0, flush}, 32'd0);
            check("rst_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge i_clk);
        #1;
        i_rst   = 1'b1;
        jmp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("idle_valid", {31'd0, redirect_valid}, 32'd0);
            check("idle_pc", redirect_pc, 32'd0);
        end
        step();

        // Directed cases
        txn(1'b1, 1'b0, 32'h0000_1235, 32'h0, 0, 1'b0);   // basic jump
        txn(1'b0, 1'b1, 32'h0, 32'h0000_0200, 4, 1'b0);   // fetch backpressure
        txn(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0300, 0, 1'b1); // jmp wins, br pulsed in flush
        txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 1'b0);   // bit-1 target
        step();

        // Reset in the middle of a pending redirect
        jmp_req     = 1'b0;
        br_req      = 1'b1;
        br_target   = 32'h0000_0800;
        fetch_ready = 1'b0;
        exp_q.push_back('{mis: 1'b0, pc: 32'h0000_0800, wait_cycles: 3});
        step();
        clear_reqs();
        step();
        #2;
        i_rst = 1'b0;
        exp_q.delete();
        #1;
        $display("[TB] reset asserted mid-REQ");
        check("midrst_valid", {31'd0, redirect_valid}, 32'd0);
        check("midrst_pc", redirect_pc, 32'd0);
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        step();
        step();
        i_rst = 1'b1;
        fetch_ready = 1'b1;
        @(negedge i_clk);
        check("post_rst_valid", {31'd0, redirect_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        txn(1'b0, 1'b1, 32'h0, 32'h0000_0A01, 1, 1'b0);   // FSM usable again

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit uj;
            bit ub;
            int gap;
            uj = 1'($urandom);
            ub = uj ? 1'($urandom) : 1'b1;
            txn(uj, ub, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
        end

        for (int i = 0; i < 8; i++) step();
        check("queue_drained", exp_q.size(), 32'd0);
        check("episode_closed", {31'd0, in_ep}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
